// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and constants for the 8-by-4 sequential restoring divider.
package div_pkg;

    localparam int DW    = 8;
    localparam int VW    = 4;
    localparam int PRW   = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step: partial remainder minus divisor.
module div_trial_sub
    import div_pkg::*;
(
    input  logic [PRW-1:0] minuend,
    input  logic [VW-1:0]  subtrahend,
    output logic [PRW-1:0] difference,
    output logic           ge
);

    logic [PRW:0] full_diff;

    // One extra bit holds the sign of the trial result.
    assign full_diff  = {1'b0, minuend} - {2'b00, subtrahend};
    assign difference = full_diff[PRW-1:0];
    assign ge         = ~full_diff[PRW];

endmodule

// File: rtl/seq_restoring_div8x4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | eight shift/trial-subtract steps
//   DONE  | result presented until out_ready
module seq_restoring_div8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          busy
);

    import div_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [DW-1:0]    dvd_shift;
    logic [VW-1:0]    dvs;
    logic [PRW-1:0]   pr;
    logic [CNT_W-1:0] count;

    logic [PRW-1:0]   pr_shift;
    logic [PRW-1:0]   trial_diff;
    logic             trial_ge;
    logic [PRW-1:0]   pr_step;

    assign pr_shift = {pr[PRW-2:0], dvd_shift[DW-1]};
    assign pr_step  = trial_ge ? trial_diff : pr_shift;

    div_trial_sub u_trial (
        .minuend    (pr_shift),
        .subtrahend (dvs),
        .difference (trial_diff),
        .ge         (trial_ge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == CALC);
        out_valid = (state == DONE);
    end

    // The dividend register doubles as the quotient accumulator: each step shifts
    // one dividend bit out of the top and one quotient bit in at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_shift   <= '0;
            dvs         <= '0;
            pr          <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient    <= DBZ_QUOTIENT;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd_shift <= dividend;
                            dvs       <= divisor;
                            pr        <= '0;
                            count     <= CNT_W'(DW - 1);
                        end
                    end
                end
                CALC: begin
                    dvd_shift <= {dvd_shift[DW-2:0], trial_ge};
                    pr        <= pr_step;
                    count     <= count - 1'b1;
                    if (count == '0) begin
                        quotient    <= {dvd_shift[DW-2:0], trial_ge};
                        remainder   <= pr_step[VW-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
